// File: rtl/lcd_frame_scanner_pkg.sv
// lcd_frame_scanner_pkg: shared RGB565 constants, default panel size and scanner state encoding
package lcd_frame_scanner_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, EMIT, DONE} state_t;
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] RED = 16'hF800;
  localparam logic [15:0] BLUE = 16'h001F;
  localparam int DEF_WIDTH = 240;
  localparam int DEF_HEIGHT = 320;
endpackage

// File: rtl/lcd_frame_scanner_if.sv
// lcd_frame_scanner_if: coordinate, layer-enable and pixel-stream bundle between scanner and its peers
interface lcd_frame_scanner_if #(
  parameter int BITS_WIDTH = 8,
  parameter int BITS_HEIGHT = 9,
  parameter int NUM_LAYERS = 4
);
  logic start;
  logic [BITS_WIDTH-1:0] xAddLCD;
  logic [BITS_HEIGHT-1:0] yAddLCD;
  logic [NUM_LAYERS-1:0] layerPixEN;
  logic [NUM_LAYERS*16-1:0] layerColours;
  logic [15:0] bgColour;
  logic [15:0] pixelData;
  logic pixelValid;
  logic pixelReady;
  logic frameBusy;
  logic frameDone;
  modport master (
    input start, layerPixEN, layerColours, bgColour, pixelReady,
    output xAddLCD, yAddLCD, pixelData, pixelValid, frameBusy, frameDone
  );
  modport slave (
    output start, layerPixEN, layerColours, bgColour, pixelReady,
    input xAddLCD, yAddLCD, pixelData, pixelValid, frameBusy, frameDone
  );
endinterface

// File: rtl/lcd_layer_priority_mux.sv
// lcd_layer_priority_mux: picks the colour of the lowest-index active layer, else the background
module lcd_layer_priority_mux #(
  parameter int NUM_LAYERS = 4
) (
  input logic [NUM_LAYERS-1:0] en,
  input logic [NUM_LAYERS*16-1:0] colours,
  input logic [15:0] bg,
  output logic [15:0] colour
);
  always_comb begin
    colour = bg;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) colour = en[i] ? colours[16*i +: 16] : colour;
  end
endmodule

// File: rtl/lcd_frame_scanner.sv
// lcd_frame_scanner: walks every LCD coordinate, resolves layer priority and streams one RGB565 frame per start
module lcd_frame_scanner
  import lcd_frame_scanner_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int BITS_WIDTH = 8,
  parameter int BITS_HEIGHT = 9,
  parameter int NUM_LAYERS = 4,
  parameter int GEN_LATENCY = 1
) (
  input logic clock,
  input logic reset,
  lcd_frame_scanner_if.master bus
);
  state_t state;
  logic [BITS_WIDTH-1:0] x;
  logic [BITS_HEIGHT-1:0] y;
  logic [1:0] cnt;
  logic [15:0] data, colour;
  logic valid, busy, done, last_x, last;
  assign last_x = x == BITS_WIDTH'(WIDTH - 1);
  assign last = last_x && (y == BITS_HEIGHT'(HEIGHT - 1));
  lcd_layer_priority_mux #(.NUM_LAYERS(NUM_LAYERS)) mux (
    .en(bus.layerPixEN),
    .colours(bus.layerColours),
    .bg(bus.bgColour),
    .colour(colour)
  );
  // coordinates move only on the accept edge, so generators always see an address long enough
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      cnt <= '0;
      data <= BLACK;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= SETTLE;
          cnt <= '0;
          busy <= 1'b1;
        end
        SETTLE: begin
          cnt <= cnt + 2'd1;
          state <= cnt == 2'(GEN_LATENCY - 1) ? SAMPLE : SETTLE;
        end
        SAMPLE: begin
          data <= colour;
          valid <= 1'b1;
          state <= EMIT;
        end
        EMIT: if (bus.pixelReady) begin
          valid <= 1'b0;
          cnt <= '0;
          state <= last ? DONE : SETTLE;
          done <= last;
          busy <= !last;
          if (!last) begin
            x <= last_x ? '0 : x + 1'b1;
            y <= last_x ? y + 1'b1 : y;
          end
        end
        DONE: begin
          x <= '0;
          y <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.xAddLCD = x;
  assign bus.yAddLCD = y;
  assign bus.pixelData = data;
  assign bus.pixelValid = valid;
  assign bus.frameBusy = busy;
  assign bus.frameDone = done;
endmodule

// File: tb/tb_lcd_frame_scanner.sv
// tb_lcd_frame_scanner: scoreboard bench for a 4x3 two-layer scanner at generator latency 1 and 2
module tb_lcd_frame_scanner;
  localparam logic [15:0] C0 = 16'hF800;
  localparam logic [15:0] C1 = 16'h001F;
  localparam logic [15:0] BG = 16'h07E0;
  typedef struct { int x; int y; logic [15:0] c; } exp_t;
  typedef struct { logic [1:0] en; logic [15:0] colour; } vec_t;
  logic clk = 0, rst = 1, ready = 1;
  int mode = 0;
  logic [1:0] en_const = 2'b00;
  int n_chk = 0, n_err = 0, cyc = 0, acc1 = 0, acc2 = 0, done1 = 0, done2 = 0, last_acc = -1;
  bit gap_chk = 0, pend_done = 0;
  exp_t q1[$], q2[$];
  exp_t e1, e2;
  vec_t tbl[4];
  logic [1:0] g1, g2a, g2b;
  lcd_frame_scanner_if #(.BITS_WIDTH(2), .BITS_HEIGHT(2), .NUM_LAYERS(2)) b1();
  lcd_frame_scanner_if #(.BITS_WIDTH(2), .BITS_HEIGHT(2), .NUM_LAYERS(2)) b2();
  lcd_frame_scanner #(.WIDTH(4), .HEIGHT(3), .BITS_WIDTH(2), .BITS_HEIGHT(2), .NUM_LAYERS(2), .GEN_LATENCY(1))
    u1 (.clock(clk), .reset(rst), .bus(b1.master));
  lcd_frame_scanner #(.WIDTH(4), .HEIGHT(3), .BITS_WIDTH(2), .BITS_HEIGHT(2), .NUM_LAYERS(2), .GEN_LATENCY(2))
    u2 (.clock(clk), .reset(rst), .bus(b2.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] pattern(int m, int x, int y);
    return m == 1 ? (x == 1 ? 2'b10 : x == 2 ? 2'b11 : 2'b00) :
           m == 2 ? {x[0], x == y} : m == 3 ? en_const : 2'b00;
  endfunction
  function automatic logic [15:0] ecol(logic [1:0] en);
    return en[0] ? C0 : en[1] ? C1 : BG;
  endfunction

  // bitmap generator models: one sync-ROM stage for u1, two for u2
  always @(posedge clk) begin
    g1 <= pattern(mode, int'(b1.xAddLCD), int'(b1.yAddLCD));
    g2a <= pattern(mode, int'(b2.xAddLCD), int'(b2.yAddLCD));
    g2b <= g2a;
  end
  assign b1.layerPixEN = g1;
  assign b2.layerPixEN = g2b;
  assign b1.layerColours = {C1, C0};
  assign b2.layerColours = {C1, C0};
  assign b1.bgColour = BG;
  assign b2.bgColour = BG;
  assign b1.pixelReady = ready;
  assign b2.pixelReady = ready;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(bit which, int m, bit fixed, logic [15:0] c);
    exp_t e;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) begin
        e.x = x;
        e.y = y;
        e.c = fixed ? c : ecol(pattern(m, x, y));
        if (which) q2.push_back(e);
        else q1.push_back(e);
      end
  endtask

  task automatic wait_frame(bit which, int d0);
    int k = 0;
    while ((which ? done2 : done1) == d0 && k < 300) begin
      tick(1);
      k++;
    end
    tick(2);
    chk("frame_done_count", (which ? done2 : done1) - d0, 1);
  endtask

  task automatic run1();
    int d0 = done1;
    acc1 = 0;
    last_acc = -1;
    b1.start = 1;
    tick(1);
    b1.start = 0;
    chk("busy_on_start", b1.frameBusy, 1);
    wait_frame(0, d0);
    chk("accepts", acc1, 12);
    chk("busy_idle", b1.frameBusy, 0);
    chk("queue_empty", q1.size(), 0);
    chk("coords_idle", {b1.xAddLCD, b1.yAddLCD}, 0);
  endtask

  task automatic reset_checks();
    chk("rst_x", b1.xAddLCD, 0);
    chk("rst_y", b1.yAddLCD, 0);
    chk("rst_data", b1.pixelData, 0);
    chk("rst_valid", b1.pixelValid, 0);
    chk("rst_busy", b1.frameBusy, 0);
    chk("rst_done", b1.frameDone, 0);
  endtask

  always @(negedge clk) if (!rst) begin
    if (pend_done) begin
      chk("done_pulse", b1.frameDone, 1);
      chk("busy_at_done", b1.frameBusy, 0);
      pend_done = 0;
    end
    if (b1.frameDone) done1++;
    if (b1.pixelValid && ready) begin
      acc1++;
      if (q1.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_pixel: got %0h at (%0d,%0d) expected none", b1.pixelData, b1.xAddLCD, b1.yAddLCD);
      end else begin
        e1 = q1.pop_front();
        chk("pix_data", b1.pixelData, e1.c);
        chk("pix_xy", {b1.xAddLCD, b1.yAddLCD}, {e1.x[1:0], e1.y[1:0]});
        if (gap_chk && last_acc >= 0) chk("pix_gap", cyc - last_acc, 3);
        last_acc = cyc;
        pend_done = e1.x == 3 && e1.y == 2;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (b2.frameDone) done2++;
    if (b2.pixelValid && ready) begin
      acc2++;
      if (q2.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_pixel_lat2: got %0h expected none", b2.pixelData);
      end else begin
        e2 = q2.pop_front();
        chk("lat2_data", b2.pixelData, e2.c);
        chk("lat2_xy", {b2.xAddLCD, b2.yAddLCD}, {e2.x[1:0], e2.y[1:0]});
      end
    end
  end

  initial begin
    int d0, k, a0;
    logic [15:0] data0;
    tbl[0] = '{2'b00, BG};
    tbl[1] = '{2'b01, C0};
    tbl[2] = '{2'b10, C1};
    tbl[3] = '{2'b11, C0};
    b1.start = 0;
    b2.start = 0;
    tick(3);
    reset_checks();
    rst = 0;
    tick(1);
    gap_chk = 1;
    mode = 0;
    push(0, 0, 0, 0);
    run1();
    mode = 1;
    push(0, 1, 0, 0);
    run1();
    mode = 3;
    for (int i = 0; i < 4; i++) begin
      en_const = tbl[i].en;
      push(0, 3, 1, tbl[i].colour);
      run1();
    end
    gap_chk = 0;
    // stall pixel 5 at (1,1)
    mode = 2;
    push(0, 2, 0, 0);
    d0 = done1;
    acc1 = 0;
    b1.start = 1;
    tick(1);
    b1.start = 0;
    k = 0;
    while (!(b1.xAddLCD == 1 && b1.yAddLCD == 1) && k < 100) begin tick(1); k++; end
    ready = 0;
    k = 0;
    while (!b1.pixelValid && k < 20) begin tick(1); k++; end
    chk("stall_valid", b1.pixelValid, 1);
    data0 = b1.pixelData;
    a0 = acc1;
    repeat (5) begin
      tick(1);
      chk("stall_hold_valid", b1.pixelValid, 1);
      chk("stall_hold_data", b1.pixelData, data0);
      chk("stall_hold_xy", {b1.xAddLCD, b1.yAddLCD}, 4'b0101);
    end
    ready = 1;
    tick(1);
    chk("stall_one_accept", acc1 - a0, 1);
    wait_frame(0, d0);
    chk("stall_accepts", acc1, 12);
    // start mid-frame and on the frameDone cycle
    push(0, 2, 0, 0);
    d0 = done1;
    acc1 = 0;
    b1.start = 1;
    tick(1);
    b1.start = 0;
    tick(10);
    b1.start = 1;
    tick(1);
    b1.start = 0;
    k = 0;
    while (!b1.frameDone && k < 200) begin tick(1); k++; end
    b1.start = 1;
    tick(1);
    b1.start = 0;
    tick(20);
    chk("ignored_start_busy", b1.frameBusy, 0);
    chk("ignored_start_accepts", acc1, 12);
    chk("ignored_start_dones", done1 - d0, 1);
    chk("ignored_start_queue", q1.size(), 0);
    // reset while pixel 7 is waiting in EMIT
    push(0, 2, 0, 0);
    d0 = done1;
    acc1 = 0;
    b1.start = 1;
    tick(1);
    b1.start = 0;
    k = 0;
    while (!(b1.pixelValid && b1.xAddLCD == 3 && b1.yAddLCD == 1) && k < 100) begin tick(1); k++; end
    rst = 1;
    tick(1);
    reset_checks();
    rst = 0;
    tick(3);
    chk("reset_no_done", done1 - d0, 0);
    chk("accepts_before_reset", acc1, 7);
    q1.delete();
    pend_done = 0;
    push(0, 2, 0, 0);
    run1();
    // generator latency 2
    push(1, 2, 0, 0);
    d0 = done2;
    acc2 = 0;
    b2.start = 1;
    tick(1);
    b2.start = 0;
    chk("lat2_busy", b2.frameBusy, 1);
    wait_frame(1, d0);
    chk("lat2_accepts", acc2, 12);
    chk("lat2_queue", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
